stage_if: RTL and testbench
===========================

Name: stage_if

Overview:
- Instruction-fetch stage: owns the PC and issues word fetches over a req/ack instruction-memory port.
- Delivers {next_pc, instr} to the decode stage through a registered if2id slot, backed by a 1-entry skid buffer.
- Accepts a branch redirect from the execute stage and a stall from the hazard logic.
- Squashes wrong-path fetches. The branch delay slot is already past IF when a redirect arrives and is unaffected.

Parameters:
RESET_PC  32'hBFC0_0000  PC fetched first after reset
NOP_INSTR  32'h0000_0000  instruction word delivered with an address-error entry

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
stall  in  1  decode cannot consume the if2id slot this cycle; slot must hold
branch_taken  in  1  redirect request from execute
branch_dest  in  32  redirect target, valid when branch_taken=1
imem_req  out  1  fetch request
imem_addr  out  32  fetch word address, stable while imem_req=1
imem_ack  in  1  completes the transfer at the rising edge where imem_req=1
imem_rdata  in  32  instruction word, valid when imem_ack=1
if2id_valid  out  1  slot holds an instruction
if2id_next_pc  out  32  fetched PC + 4 (or the faulting PC on an address error)
if2id_instr  out  32  instruction word
if2id_addr_err  out  1  entry is a misaligned-fetch error

Behaviour:
- Reset (rst=0, async) sets:
  - pc=RESET_PC, state=FETCH;
  - if2id_valid=0, if2id_addr_err=0, if2id_next_pc=0, if2id_instr=0;
  - skid buffer empty, redirect-pending flag clear.
  - imem_req=0 while rst=0.
- imem_req and imem_addr are combinational from registered state.
  - imem_req=1 iff state is FETCH or DRAIN and pc[1:0]==0.
  - imem_addr=pc.
  - imem_req rises in the first cycle after rst deasserts, with imem_addr=RESET_PC.
- Slot consumption: the slot is consumed at an edge where if2id_valid=1 and stall=0. "Slot free" means valid=0 or being consumed.
- FETCH state, on ack:
  - slot free: slot <= {pc+4, imem_rdata, err=0}, valid=1, pc += 4, stay in FETCH. With ack tied high this gives zero-wait throughput of 1 instruction/cycle.
  - slot blocked (valid=1 and stall=1): skid <= {pc+4, imem_rdata}, pc += 4, go to HOLD.
- FETCH state, no ack: if the slot is consumed, valid<=0 (bubble).
- HOLD state:
  - imem_req=0.
  - When stall=0, the slot is loaded from the skid, the skid empties, and the state returns to FETCH.
- FETCH with pc[1:0]!=0:
  - No request is issued.
  - When the slot is free, it is loaded with {next_pc=pc, instr=NOP_INSTR, addr_err=1, valid=1} and the state goes to HALT.
- HALT state:
  - imem_req=0.
  - The slot drains normally.
  - Only a redirect or reset leaves HALT.
- Redirect (branch_taken=1) has priority over stall and ack in every state:
  - if2id_valid<=0 and skid cleared, even if stall=1.
  - pc <= branch_dest.
  - In FETCH without ack, the memory transfer cannot be aborted: go to DRAIN. imem_addr keeps the old pc via a separate drain-address register.
  - In FETCH with ack in the same cycle, the returned data is discarded and the state goes to FETCH at the new pc.
  - In HOLD or HALT, go to FETCH.
  - In DRAIN, overwrite the pending target and stay in DRAIN.
- DRAIN state:
  - imem_req=1 with the drain address.
  - On ack the data is discarded and the state goes to FETCH with pc=target.
  - if2id_valid stays 0.
- pc arithmetic is 32-bit modulo: 32'hFFFF_FFFC + 4 wraps to 0 with no flag.
- imem_addr must not change while imem_req=1 and imem_ack=0, except on DRAIN entry, where it is also held.
- Reset asserted mid-transfer drops imem_req immediately. Any late ack is ignored.

Test Plan:
1. Reset release with ack tied high → imem_addr is BFC00000, BFC00004, BFC00008 on successive cycles. The slot shows next_pc BFC00004 with instr = rdata one cycle after each fetch, valid held 1.
2. Two-cycle-latency memory (ack every other cycle), stall=0 → valid alternates 1/0. imem_addr is stable across each wait cycle.
3. Zero-wait memory, stall held high for 3 cycles after the first delivery → slot frozen at next_pc BFC00004. The second word goes to the skid, imem_req=0 in HOLD. After the stall releases, the slot shows BFC00008, then BFC0000C, with no instruction lost or duplicated.
4. branch_taken=1 with branch_dest=00001000 while a fetch is outstanding with no ack → state DRAIN, imem_addr unchanged. The late ack's rdata is never delivered, and the next request is to 00001000.
5. branch_taken=1 with branch_dest=00001002 → one error entry: valid=1, addr_err=1, instr=0, next_pc=00001002. After that, imem_req stays 0 until a redirect to 00002000 resumes fetching.
6. rst pulled low while imem_req=1 → imem_req=0 immediately and the slot invalid. After release, fetch restarts at BFC00000.

Source files
------------

// File: rtl/stage_if.sv
// Instruction-fetch stage: owns the PC, fetches words over a req/ack port and
// hands {next_pc, instr} to decode through a registered slot with a 1-entry skid.
module stage_if #(
  parameter logic [31:0] RESET_PC  = 32'hBFC0_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_dest,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        if2id_valid,
  output logic [31:0] if2id_next_pc,
  output logic [31:0] if2id_instr,
  output logic        if2id_addr_err
);

  localparam int unsigned XLEN = 32;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    DRAIN = 2'd2,
    HALT  = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic [XLEN-1:0]   drain_addr_q, drain_addr_d;
  logic [XLEN-1:0]   skid_pc_q, skid_pc_d;
  logic [XLEN-1:0]   skid_instr_q, skid_instr_d;
  logic              valid_d, err_d;
  logic [XLEN-1:0]   next_pc_d, instr_d;

  logic              aligned, xfer, consume, slot_free;
  logic [XLEN-1:0]   pc_plus4;

  // Memory port is combinational from registered state, gated off during reset.
  assign aligned   = (pc_q[1:0] == 2'b00);
  assign imem_addr = (state_q == DRAIN) ? drain_addr_q : pc_q;
  assign imem_req  = rst & (((state_q == FETCH) & aligned) | (state_q == DRAIN));
  assign xfer      = imem_req & imem_ack;
  assign consume   = if2id_valid & ~stall;
  assign slot_free = ~if2id_valid | ~stall;
  assign pc_plus4  = pc_q + XLEN'(4);

  // Next-state, PC, skid and slot update; redirect dominates stall and ack.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    drain_addr_d = drain_addr_q;
    skid_pc_d    = skid_pc_q;
    skid_instr_d = skid_instr_q;
    valid_d      = if2id_valid;
    next_pc_d    = if2id_next_pc;
    instr_d      = if2id_instr;
    err_d        = if2id_addr_err;

    if (branch_taken) begin
      valid_d = 1'b0;
      err_d   = 1'b0;
      pc_d    = branch_dest;
      unique case (state_q)
        FETCH: begin
          // An in-flight request cannot be withdrawn; finish it at the old address.
          if (imem_req && !imem_ack) begin
            state_d      = DRAIN;
            drain_addr_d = pc_q;
          end else begin
            state_d = FETCH;
          end
        end
        DRAIN:   state_d = xfer ? FETCH : DRAIN;
        default: state_d = FETCH;
      endcase
    end else begin
      unique case (state_q)
        FETCH: begin
          if (!aligned) begin
            if (slot_free) begin
              valid_d   = 1'b1;
              next_pc_d = pc_q;
              instr_d   = NOP_INSTR;
              err_d     = 1'b1;
              state_d   = HALT;
            end
          end else if (xfer) begin
            pc_d = pc_plus4;
            if (slot_free) begin
              valid_d   = 1'b1;
              next_pc_d = pc_plus4;
              instr_d   = imem_rdata;
              err_d     = 1'b0;
            end else begin
              skid_pc_d    = pc_plus4;
              skid_instr_d = imem_rdata;
              state_d      = HOLD;
            end
          end else if (consume) begin
            valid_d = 1'b0;
          end
        end
        HOLD: begin
          if (!stall) begin
            valid_d   = 1'b1;
            next_pc_d = skid_pc_q;
            instr_d   = skid_instr_q;
            err_d     = 1'b0;
            state_d   = FETCH;
          end
        end
        DRAIN: begin
          if (xfer) state_d = FETCH;
        end
        HALT: begin
          if (consume) valid_d = 1'b0;
        end
        default: state_d = FETCH;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= FETCH;
      pc_q           <= RESET_PC;
      drain_addr_q   <= '0;
      skid_pc_q      <= '0;
      skid_instr_q   <= '0;
      if2id_valid    <= 1'b0;
      if2id_next_pc  <= '0;
      if2id_instr    <= '0;
      if2id_addr_err <= 1'b0;
    end else begin
      state_q        <= state_d;
      pc_q           <= pc_d;
      drain_addr_q   <= drain_addr_d;
      skid_pc_q      <= skid_pc_d;
      skid_instr_q   <= skid_instr_d;
      if2id_valid    <= valid_d;
      if2id_next_pc  <= next_pc_d;
      if2id_instr    <= instr_d;
      if2id_addr_err <= err_d;
    end
  end

endmodule

// File: tb/tb_stage_if.sv
// Directed bench for stage_if: a scoreboard queue holds the entries decode
// should see, pushed when the bench completes a fetch and popped on consumption.
module tb_stage_if;

  localparam logic [31:0] NOP = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_dest;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        if2id_valid;
  logic [31:0] if2id_next_pc;
  logic [31:0] if2id_instr;
  logic        if2id_addr_err;

  typedef struct {
    logic [31:0] npc;
    logic [31:0] ins;
    logic        err;
  } ent_t;

  ent_t q[$];
  int   n_assert = 0;
  int   n_fail   = 0;

  stage_if dut (
    .clk           (clk),
    .rst           (rst),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_dest   (branch_dest),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ack      (imem_ack),
    .imem_rdata    (imem_rdata),
    .if2id_valid   (if2id_valid),
    .if2id_next_pc (if2id_next_pc),
    .if2id_instr   (if2id_instr),
    .if2id_addr_err(if2id_addr_err)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] word(input logic [31:0] a);
    return a ^ 32'h5A5A_1234;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One cycle, entered at a falling edge: check outputs, drive inputs, update scoreboard.
  task automatic tick(input bit ack, input bit stl, input bit br, input logic [31:0] dest,
                      input bit ereq, input logic [31:0] eaddr, input bit keep, input bit perr);
    ent_t e;
    #1;
    chk("imem_req", 32'(imem_req), 32'(ereq));
    if (ereq) chk("imem_addr", imem_addr, eaddr);
    chk("if2id_valid", 32'(if2id_valid), 32'(q.size() != 0));
    imem_ack     = ack;
    imem_rdata   = ack ? word(eaddr) : 32'hDEAD_BEEF;
    stall        = stl;
    branch_taken = br;
    branch_dest  = dest;
    if (if2id_valid && !stl && q.size() != 0) begin
      e = q.pop_front();
      chk("slot_next_pc", if2id_next_pc, e.npc);
      chk("slot_instr", if2id_instr, e.ins);
      chk("slot_addr_err", 32'(if2id_addr_err), 32'(e.err));
    end
    if (br) q.delete();
    else if (ack && ereq && keep) q.push_back('{eaddr + 32'd4, word(eaddr), 1'b0});
    else if (perr) q.push_back('{eaddr, NOP, 1'b1});
    @(negedge clk);
  endtask

  // Reset applied mid-cycle with a stray ack present; outputs must drop at once.
  task automatic do_reset();
    #1;
    rst          = 1'b0;
    imem_ack     = 1'b1;
    imem_rdata   = 32'hBAD0_BAD0;
    stall        = 1'b0;
    branch_taken = 1'b0;
    #1;
    chk("rst_imem_req", 32'(imem_req), 32'd0);
    chk("rst_valid", 32'(if2id_valid), 32'd0);
    chk("rst_next_pc", if2id_next_pc, 32'd0);
    chk("rst_instr", if2id_instr, 32'd0);
    chk("rst_addr_err", 32'(if2id_addr_err), 32'd0);
    q.delete();
    @(negedge clk);
    @(negedge clk);
    chk("rst_hold_valid", 32'(if2id_valid), 32'd0);
    imem_ack = 1'b0;
    rst      = 1'b1;
  endtask

  initial begin
    stall        = 1'b0;
    branch_taken = 1'b0;
    branch_dest  = '0;
    imem_ack     = 1'b0;
    imem_rdata   = '0;
    @(negedge clk);
    do_reset();

    // Zero-wait streaming from the reset vector.
    tick(1, 0, 0, 0, 1, 32'hBFC0_0000, 1, 0);
    tick(1, 0, 0, 0, 1, 32'hBFC0_0004, 1, 0);
    chk("t1_valid_held", 32'(if2id_valid), 32'd1);
    tick(1, 0, 0, 0, 1, 32'hBFC0_0008, 1, 0);
    tick(1, 0, 0, 0, 1, 32'hBFC0_000C, 1, 0);

    // Two-cycle memory: address holds through the wait cycle, valid alternates.
    for (int i = 0; i < 3; i++) begin
      tick(0, 0, 0, 0, 1, 32'hBFC0_0010 + 32'(i * 4), 1, 0);
      tick(1, 0, 0, 0, 1, 32'hBFC0_0010 + 32'(i * 4), 1, 0);
    end
    tick(0, 0, 0, 0, 1, 32'hBFC0_001C, 1, 0);

    // Stall with zero-wait memory: second word parks in the skid.
    do_reset();
    tick(1, 0, 0, 0, 1, 32'hBFC0_0000, 1, 0);
    tick(1, 1, 0, 0, 1, 32'hBFC0_0004, 1, 0);
    tick(0, 1, 0, 0, 0, 0, 1, 0);
    chk("t3_frozen_pc", if2id_next_pc, 32'hBFC0_0004);
    tick(0, 1, 0, 0, 0, 0, 1, 0);
    tick(0, 0, 0, 0, 0, 0, 1, 0);
    tick(1, 0, 0, 0, 1, 32'hBFC0_0008, 1, 0);
    tick(0, 0, 0, 0, 1, 32'hBFC0_000C, 1, 0);

    // Redirect with an outstanding fetch: drain at the old address, drop its data.
    tick(0, 0, 1, 32'h0000_1000, 1, 32'hBFC0_000C, 1, 0);
    tick(0, 0, 0, 0, 1, 32'hBFC0_000C, 1, 0);
    tick(1, 0, 0, 0, 1, 32'hBFC0_000C, 0, 0);
    tick(1, 0, 0, 0, 1, 32'h0000_1000, 1, 0);
    tick(0, 0, 0, 0, 1, 32'h0000_1004, 1, 0);

    // Redirect to a misaligned target on an acked cycle: one error entry, then halt.
    tick(1, 0, 1, 32'h0000_1002, 1, 32'h0000_1004, 1, 0);
    tick(0, 0, 0, 0, 0, 32'h0000_1002, 0, 1);
    tick(0, 0, 0, 0, 0, 0, 1, 0);
    tick(0, 0, 0, 0, 0, 0, 1, 0);
    tick(0, 0, 1, 32'h0000_2000, 0, 0, 1, 0);
    tick(1, 0, 0, 0, 1, 32'h0000_2000, 1, 0);
    tick(0, 0, 0, 0, 1, 32'h0000_2004, 1, 0);

    // PC wraps from the top of the address space to zero.
    tick(1, 0, 1, 32'hFFFF_FFFC, 1, 32'h0000_2004, 1, 0);
    tick(1, 0, 0, 0, 1, 32'hFFFF_FFFC, 1, 0);
    tick(1, 0, 0, 0, 1, 32'h0000_0000, 1, 0);
    chk("wrap_next_pc", if2id_next_pc, 32'h0000_0004);

    // Reset mid-transfer with a full slot, then restart from the reset vector.
    chk("pre_rst_req", 32'(imem_req), 32'd1);
    do_reset();
    tick(1, 0, 0, 0, 1, 32'hBFC0_0000, 1, 0);
    tick(0, 0, 0, 0, 1, 32'hBFC0_0004, 1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
